operand_feeder: RTL and testbench
=================================

// Module: operand_feeder
// PURPOSE
//   Upstream stage of main (controller + datapath). Accepts operand pairs from a host over a
//   valid/ready handshake and buffers them in a small FIFO. Issues one pair at a time into the
//   datapath R1/R2 load path, then releases the freeze input E and waits for the LD_outr pulse.
//   Captures outr on that pulse as the job result. Holds main frozen (E=1) while it has no work.
//   Includes a watchdog for jobs that never complete.
// PARAMETERS
//   WIDTH    4    operand/result width; matches the datapath R1/R2/outr width
//   DEPTH    4    FIFO entries (operand pairs); power of two, >=2
//   TIMEOUT  15   max cycles in RUN without LD_outr before the error path is taken
// PORTS
//   clk         in   1      single clock; all logic on the rising edge
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      host offers a pair
//   in_ready    out  1      = !fifo_full; push occurs when in_valid & in_ready
//   in_a        in   WIDTH  operand destined for R1
//   in_b        in   WIDTH  operand destined for R2
//   op_R1       out  WIDTH  registered operand to datapath R1
//   op_R2       out  WIDTH  registered operand to datapath R2
//   LD_op       out  1      one-cycle strobe: datapath loads op_R1/op_R2 into R1/R2
//   E           out  1      freeze to main; 1 = frozen
//   LD_outr     in   1      from main controller: outr is valid this cycle
//   outr        in   WIDTH  datapath result
//   result      out  WIDTH  captured outr of the last completed job
//   result_vld  out  1      one-cycle pulse, asserted the cycle after capture
//   busy        out  1      state != IDLE
//   err         out  1      sticky watchdog flag; cleared only by rst
//   jobs_done   out  8      completed-job counter; wraps 255->0
// BEHAVIOUR
//   Reset (sync, rst=1 at an edge)
//     - FIFO emptied; state=IDLE.
//     - Outputs: E=1, LD_op=0, op_R1=op_R2=0, result=0, result_vld=0, err=0, jobs_done=0, busy=0.
//     - in_ready=1 in the cycle after reset.
//     - Mid-job reset aborts the job with no result_vld; E=1 from the next cycle.
//   FIFO
//     - Push when in_valid & in_ready. Pop only in IDLE when not empty.
//     - Push and pop in the same cycle: count unchanged.
//     - Full: in_ready=0, even if a pop happens that cycle. There is no full-bypass.
//     - Empty: no empty-bypass; a pair pushed into an empty FIFO is popped at the earliest
//       one cycle later.
//   State machine (2-bit)
//     IDLE: E=1.
//       - Not empty: pop, latch op_R1/op_R2 -> LOAD.
//     LOAD: LD_op=1 for exactly this cycle; E=1 -> RUN. timer cleared.
//     RUN:  E=0; timer increments each cycle.
//       - LD_outr=1: result<=outr, jobs_done++ -> DONE.
//       - Else if timer==TIMEOUT: err<=1 -> IDLE (E=1 next cycle).
//       - LD_outr wins over timeout in the same cycle.
//     DONE: result_vld=1, E=1 -> IDLE.
//   Latency
//     - Push into an empty idle block -> LD_op asserted 2 cycles later.
//     - E falls 3 cycles after the push.
//   LD_outr outside RUN is ignored: no capture, no count.
//   Back-to-back jobs: minimum 4 cycles per job.
//   Arithmetic
//     - timer width = clog2(TIMEOUT+1).
//     - jobs_done is modulo 256.
// STRUCTURE
//   - Package ca_pkg: state encodings FEED_IDLE=0, FEED_LOAD=1, FEED_RUN=2, FEED_DONE=3;
//     default WIDTH.
//   - Sub-module pair_fifo (WIDTH*2 data, DEPTH); FSM, timer and capture registers stay in top.
// TESTING
//   1. rst=1 for 2 edges, then 0 -> E=1, in_ready=1, every other output 0, busy=0.
//   2. Push (3,5); LD_outr with outr=8 on the 4th RUN cycle
//      -> LD_op 2 cycles after push with op_R1=3, op_R2=5;
//      -> result=8, result_vld pulses once, jobs_done=1, E back to 1.
//   3. Push 5 pairs with DEPTH=4 and no pops
//      -> in_ready=0 after 4 pushes; the 5th is accepted only after the first pop.
//      -> Pairs issue in FIFO order.
//   4. Push (1,2), never assert LD_outr
//      -> after 16 RUN cycles err=1, E=1, jobs_done=0.
//      -> The next queued pair still issues.
//   5. LD_outr on exactly the timeout cycle -> job completes, err stays 0.
//   6. rst in RUN with 2 pairs queued
//      -> FIFO empty, E=1, no result_vld;
//      -> a pulsed LD_outr afterwards is ignored.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types for the operand feeder: FSM state encoding and default operand width.
package ca_pkg;

  localparam int unsigned FEED_WIDTH = 4;

  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    FEED_LOAD = 2'd1,
    FEED_RUN  = 2'd2,
    FEED_DONE = 2'd3
  } feed_state_t;

endpackage

// File: rtl/operand_feeder_fifo.sv
// Operand-pair FIFO: registered count, no full or empty bypass.
module pair_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/operand_feeder.sv
// Buffers host operand pairs and issues them one job at a time into the datapath,
// holding it frozen between jobs and flagging jobs that never complete.
module operand_feeder
  import ca_pkg::*;
#(
  parameter int unsigned WIDTH   = FEED_WIDTH,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] op_R1,
  output logic [WIDTH-1:0] op_R2,
  output logic             LD_op,
  output logic             E,
  input  logic             LD_outr,
  input  logic [WIDTH-1:0] outr,
  output logic [WIDTH-1:0] result,
  output logic             result_vld,
  output logic             busy,
  output logic             err,
  output logic [7:0]       jobs_done
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  feed_state_t        state_q;
  logic [TW-1:0]      timer_q;
  logic [2*WIDTH-1:0] pair;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == FEED_IDLE) && !fifo_empty;
  assign busy     = (state_q != FEED_IDLE);

  pair_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({in_a, in_b}),
    .pop_i   (pop),
    .data_o  (pair),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs are registered against the state being entered, so E/LD_op/result_vld
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FEED_IDLE;
      timer_q    <= '0;
      E          <= 1'b1;
      LD_op      <= 1'b0;
      op_R1      <= '0;
      op_R2      <= '0;
      result     <= '0;
      result_vld <= 1'b0;
      err        <= 1'b0;
      jobs_done  <= '0;
    end else begin
      case (state_q)
        FEED_IDLE: begin
          E          <= 1'b1;
          result_vld <= 1'b0;
          if (!fifo_empty) begin
            op_R1   <= pair[2*WIDTH-1:WIDTH];
            op_R2   <= pair[WIDTH-1:0];
            LD_op   <= 1'b1;
            state_q <= FEED_LOAD;
          end
        end
        FEED_LOAD: begin
          LD_op   <= 1'b0;
          E       <= 1'b0;
          timer_q <= '0;
          state_q <= FEED_RUN;
        end
        FEED_RUN: begin
          if (LD_outr) begin
            result     <= outr;
            jobs_done  <= jobs_done + 8'd1;
            result_vld <= 1'b1;
            E          <= 1'b1;
            state_q    <= FEED_DONE;
          end else if (timer_q == TW'(TIMEOUT)) begin
            err     <= 1'b1;
            E       <= 1'b1;
            state_q <= FEED_IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        FEED_DONE: begin
          result_vld <= 1'b0;
          E          <= 1'b1;
          state_q    <= FEED_IDLE;
        end
        default: state_q <= FEED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Directed self-checking bench for operand_feeder (WIDTH=4, DEPTH=4, TIMEOUT=15).
module tb_operand_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic [3:0] op_R1;
  logic [3:0] op_R2;
  logic       LD_op;
  logic       E;
  logic       LD_outr = 1'b0;
  logic [3:0] outr = '0;
  logic [3:0] result;
  logic       result_vld;
  logic       busy;
  logic       err;
  logic [7:0] jobs_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_feeder #(
    .WIDTH   (4),
    .DEPTH   (4),
    .TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .op_R1      (op_R1),
    .op_R2      (op_R2),
    .LD_op      (LD_op),
    .E          (E),
    .LD_outr    (LD_outr),
    .outr       (outr),
    .result     (result),
    .result_vld (result_vld),
    .busy       (busy),
    .err        (err),
    .jobs_done  (jobs_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ld(input string tag, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    while (!LD_op && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_ld_op"}, 32'(LD_op), 32'd1);
    check({tag, "_op_R1"}, 32'(op_R1), 32'(a));
    check({tag, "_op_R2"}, 32'(op_R2), 32'(b));
  endtask

  // Called during a RUN cycle: completes the job with the given result.
  task automatic finish_job(input string tag, input logic [3:0] val, input logic [7:0] jobs);
    LD_outr = 1'b1;
    outr    = val;
    tick();
    LD_outr = 1'b0;
    check({tag, "_result"}, 32'(result), 32'(val));
    check({tag, "_vld"}, 32'(result_vld), 32'd1);
    check({tag, "_jobs"}, 32'(jobs_done), 32'(jobs));
    check({tag, "_E_done"}, 32'(E), 32'd1);
    tick();
    check({tag, "_vld_off"}, 32'(result_vld), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // 1. reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_E", 32'(E), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_LD_op", 32'(LD_op), 32'd0);
    check("rst_op_R1", 32'(op_R1), 32'd0);
    check("rst_op_R2", 32'(op_R2), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_vld", 32'(result_vld), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_jobs", 32'(jobs_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 2. single job (3,5), completes on the 4th RUN cycle with outr=8
    push_one(4'd3, 4'd5);
    check("j1_no_ld_yet", 32'(LD_op), 32'd0);
    check("j1_busy0", 32'(busy), 32'd0);
    tick();
    check("j1_ld_op", 32'(LD_op), 32'd1);
    check("j1_op_R1", 32'(op_R1), 32'd3);
    check("j1_op_R2", 32'(op_R2), 32'd5);
    check("j1_E_load", 32'(E), 32'd1);
    tick();
    check("j1_E_run", 32'(E), 32'd0);
    check("j1_ld_off", 32'(LD_op), 32'd0);
    tick();
    tick();
    tick();
    check("j1_E_run4", 32'(E), 32'd0);
    finish_job("j1", 4'd8, 8'd1);

    // 3. fill the FIFO behind an in-flight job; 5th queued pair waits for a pop
    in_valid = 1'b1; in_a = 4'd4; in_b = 4'd1;
    tick();
    in_a = 4'd6; in_b = 4'd7;
    tick();
    check("f_p0_ld", 32'(LD_op), 32'd1);
    check("f_p0_R1", 32'(op_R1), 32'd4);
    check("f_p0_R2", 32'(op_R2), 32'd1);
    in_a = 4'd8; in_b = 4'd9;
    tick();
    in_a = 4'd10; in_b = 4'd11;
    tick();
    check("f_ready_3", 32'(in_ready), 32'd1);
    in_a = 4'd12; in_b = 4'd13;
    tick();
    check("f_full", 32'(in_ready), 32'd0);
    in_a = 4'd14; in_b = 4'd15;
    LD_outr = 1'b1; outr = 4'd2;
    tick();
    LD_outr = 1'b0;
    check("f_full_done", 32'(in_ready), 32'd0);
    check("f_p0_result", 32'(result), 32'd2);
    check("f_p0_jobs", 32'(jobs_done), 32'd2);
    tick();
    check("f_full_idle", 32'(in_ready), 32'd0);
    tick();
    check("f_ready_after_pop", 32'(in_ready), 32'd1);
    check("f_p1_ld", 32'(LD_op), 32'd1);
    check("f_p1_R1", 32'(op_R1), 32'd6);
    check("f_p1_R2", 32'(op_R2), 32'd7);
    tick();
    in_valid = 1'b0;
    check("f_p5_accepted", 32'(in_ready), 32'd0);
    finish_job("f_p1", 4'd3, 8'd3);
    wait_ld("f_p2", 4'd8, 4'd9);
    tick();
    finish_job("f_p2", 4'd4, 8'd4);
    wait_ld("f_p3", 4'd10, 4'd11);
    tick();
    finish_job("f_p3", 4'd5, 8'd5);
    wait_ld("f_p4", 4'd12, 4'd13);
    tick();
    finish_job("f_p4", 4'd6, 8'd6);
    wait_ld("f_p5", 4'd14, 4'd15);
    tick();
    finish_job("f_p5", 4'd7, 8'd7);

    // 4. watchdog: job (1,2) never completes, (5,6) still issues afterwards
    do_reset();
    push_one(4'd1, 4'd2);
    push_one(4'd5, 4'd6);
    wait_ld("wd", 4'd1, 4'd2);
    tick();
    check("wd_E_run1", 32'(E), 32'd0);
    repeat (15) tick();
    check("wd_run16_err", 32'(err), 32'd0);
    check("wd_run16_E", 32'(E), 32'd0);
    tick();
    check("wd_err", 32'(err), 32'd1);
    check("wd_E", 32'(E), 32'd1);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_jobs", 32'(jobs_done), 32'd0);
    check("wd_vld", 32'(result_vld), 32'd0);
    wait_ld("wd_next", 4'd5, 4'd6);
    tick();
    finish_job("wd_next", 4'd9, 8'd1);
    check("wd_err_sticky", 32'(err), 32'd1);

    // 5. LD_outr on the exact timeout cycle wins
    do_reset();
    check("to_err_clr", 32'(err), 32'd0);
    push_one(4'd7, 4'd3);
    wait_ld("to", 4'd7, 4'd3);
    tick();
    repeat (15) tick();
    check("to_run16_busy", 32'(busy), 32'd1);
    check("to_run16_E", 32'(E), 32'd0);
    finish_job("to", 4'd10, 8'd1);
    check("to_err", 32'(err), 32'd0);

    // 6. reset mid-RUN with 2 pairs queued
    push_one(4'd1, 4'd1);
    push_one(4'd2, 4'd2);
    push_one(4'd3, 4'd3);
    tick();
    check("mr_in_run", 32'(E), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_E", 32'(E), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_vld", 32'(result_vld), 32'd0);
    check("mr_jobs", 32'(jobs_done), 32'd0);
    check("mr_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    check("mr_fifo_empty_busy", 32'(busy), 32'd0);
    check("mr_fifo_empty_ld", 32'(LD_op), 32'd0);
    LD_outr = 1'b1; outr = 4'd15;
    tick();
    LD_outr = 1'b0;
    check("mr_ign_result", 32'(result), 32'd0);
    check("mr_ign_jobs", 32'(jobs_done), 32'd0);
    check("mr_ign_vld", 32'(result_vld), 32'd0);
    tick();
    check("mr_ign_vld2", 32'(result_vld), 32'd0);
    check("mr_ign_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
